imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  - Shares one single-port instruction memory between the CPU fetch port (F, read-only) and a
//    program-loader/debug port (L, read/write).
//  - Sits between the PC/fetch logic and the instruction memory array.
//  - One memory access per cycle; 2-way round-robin on contention; registered read response.
// PARAMETERS
//  DW        32  data width of memory word
//  AW        5   word-address width (32 words)
//  MAX_LOCK  8   max consecutive L grants while locked (LOADER_LOCK_EN only)
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   reset, asynchronous, active-high
//  f_req      in   1   fetch requests a read; held until f_gnt
//  f_addr     in   AW  fetch word address
//  f_gnt      out  1   fetch access issued this cycle (combinational)
//  f_rvalid   out  1   f_rdata valid (one cycle after f_gnt)
//  f_rdata    out  DW  fetched instruction
//  l_req      in   1   loader requests an access; held until l_gnt
//  l_we       in   1   1 = write, 0 = read
//  l_addr     in   AW  loader word address
//  l_wdata    in   DW  loader write data
//  l_lock     in   1   request consecutive grants (LOADER_LOCK_EN only; ignored otherwise)
//  l_gnt      out  1   loader access issued this cycle (combinational)
//  l_rvalid   out  1   loader access complete (one cycle after l_gnt, reads and writes)
//  l_rdata    out  DW  read data; 0 for a write ack
//  mem_addr   out  AW  memory address (muxed)
//  mem_we     out  1   memory write enable
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, combinational from mem_addr
// BEHAVIOUR
//  - Reset: all *_gnt, *_rvalid, mem_we = 0; f_rdata, l_rdata = 0.
//    last_gnt = L, so F wins the first contention; FSM = ARB; lock count = 0.
//  - Grant (ARB): only one req -> grant it. Both -> grant the side != last_gnt.
//    last_gnt updates on every grant. At most one gnt high per cycle.
//  - Granted cycle N: mem_addr/mem_we/mem_wdata driven from the winner.
//    mem_we = l_gnt & l_we. mem_rdata is registered into winner's rdata.
//    Winner's rvalid = 1 in cycle N+1 only.
//  - Idle cycle (no req): mem_addr holds its previous value, mem_we = 0.
//  - Back-to-back: throughput 1 access/cycle. Each requester may present a new request in N+1
//    while its rvalid is high.
//  - A requester dropping req before gnt is legal; nothing is issued for it.
//  - Simultaneous L write and F read of same address: the arbiter grants one; F sees old data
//    if F wins, new data on a later read.
//  - RST mid-operation: pending rvalid is discarded (forced 0); no memory write in reset.
// CONFIGURATION
//  LOADER_LOCK_EN defined:
//  - FSM states ARB, LOCK. ARB -> LOCK when l_gnt & l_lock.
//  - In LOCK, L has absolute priority while l_req & l_lock; lock count increments per L grant.
//  - LOCK -> ARB when l_lock = 0, when l_req = 0, or after MAX_LOCK grants. Count resets on
//    exit. After a MAX_LOCK exit, last_gnt = L, so a waiting F wins next.
//  LOADER_LOCK_EN undefined:
//  - l_lock ignored; FSM is ARB only (pure round-robin).
// STRUCTURE
//  - Package imem_arb_pkg: default DW/AW, localparams GNT_F=1'b0 and GNT_L=1'b1, typedef of
//    arb_state_t {ARB, LOCK}.
//  - Sub-module imem_rr_pick: 2-way round-robin picker (req[1:0], last -> gnt[1:0]).
// TESTING
//  1. Reset, F only: f_addr 0..3 on consecutive cycles -> f_gnt every cycle;
//     f_rvalid/f_rdata = mem[0..3] one cycle later each.
//  2. L write 0xDEADBEEF @5, then F read @5 -> l_rvalid + l_rdata = 0, then f_rdata = 0xDEADBEEF.
//  3. F and L both req continuously from reset -> grants F,L,F,L...; never both gnt in a cycle.
//  4. LOADER_LOCK_EN, MAX_LOCK = 8, L lock + 12 writes, F req high -> 8 L grants, then 1 F grant,
//     then L resumes.
//  5. Assert RST the cycle after f_gnt -> f_rvalid stays 0; all outputs at reset values
//     asynchronously.
//  6. L read @31 (top address) while idle -> mem_addr = 31; l_rdata = mem[31] next cycle;
//     mem_we = 0 throughout.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// GNT_F/GNT_L encode which side owned the last grant.
package imem_arb_pkg;

   localparam int   DW_DEF = 32;
   localparam int   AW_DEF = 5;
   localparam logic GNT_F  = 1'b0;
   localparam logic GNT_L  = 1'b1;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

endpackage

// File: rtl/imem_rr_pick.sv
// Two-way round-robin picker: bit 0 is the fetch side, bit 1 the loader side.
// A lone request always wins; on contention the side that did not win last goes.
module imem_rr_pick
   import imem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_i == GNT_L) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port instruction memory between CPU fetch (F) and a loader/debug port (L).
// Define LOADER_LOCK_EN to let L hold the memory for up to MAX_LOCK consecutive grants.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int MAX_LOCK = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   input  logic          l_lock,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   logic          last_q;
   logic          last_d;
   logic [1:0]    pick_s;
   logic          f_gnt_s;
   logic          l_gnt_s;
   logic [AW-1:0] addr_q;
   logic          f_rvalid_q;
   logic          l_rvalid_q;
   logic [DW-1:0] f_rdata_q;
   logic [DW-1:0] l_rdata_q;

   imem_rr_pick u_pick (
      .req_i  ({l_req, f_req}),
      .last_i (last_q),
      .gnt_o  (pick_s)
   );

`ifdef LOADER_LOCK_EN
   localparam int CW = $clog2(MAX_LOCK + 1);

   arb_state_t    state_q;
   arb_state_t    state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          hold_s;

   // The exit on the MAX_LOCK-th grant guarantees hold_s never exceeds the budget.
   assign hold_s = (state_q == LOCK) && l_req && l_lock;

   always_comb begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
      if (RST) begin
         f_gnt_s = 1'b0;
         l_gnt_s = 1'b0;
      end else if (hold_s) begin
         l_gnt_s = 1'b1;
      end else begin
         f_gnt_s = pick_s[0];
         l_gnt_s = pick_s[1];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB: begin
            if (l_gnt_s && l_lock && (MAX_LOCK > 32'sd1)) begin
               state_d = LOCK;
               cnt_d   = CW'(1);
            end else begin
               state_d = ARB;
               cnt_d   = '0;
            end
         end
         LOCK: begin
            if (hold_s && (cnt_q != CW'(MAX_LOCK - 1))) begin
               state_d = LOCK;
               cnt_d   = cnt_q + CW'(1);
            end else begin
               state_d = ARB;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ARB;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ARB;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   localparam int unused_max_lock = MAX_LOCK;
   logic          unused_lock_s;

   assign unused_lock_s = l_lock;

   always_comb begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
      if (RST) begin
         f_gnt_s = 1'b0;
         l_gnt_s = 1'b0;
      end else begin
         f_gnt_s = pick_s[0];
         l_gnt_s = pick_s[1];
      end
   end
`endif

   // Idle cycles keep the last issued address on the memory bus.
   always_comb begin
      mem_addr = addr_q;
      last_d   = last_q;
      if (f_gnt_s) begin
         mem_addr = f_addr;
         last_d   = GNT_F;
      end else if (l_gnt_s) begin
         mem_addr = l_addr;
         last_d   = GNT_L;
      end else begin
         mem_addr = addr_q;
         last_d   = last_q;
      end
   end

   assign mem_we    = l_gnt_s & l_we;
   assign mem_wdata = l_gnt_s ? l_wdata : '0;
   assign f_gnt     = f_gnt_s;
   assign l_gnt     = l_gnt_s;
   assign f_rvalid  = f_rvalid_q;
   assign l_rvalid  = l_rvalid_q;
   assign f_rdata   = f_rdata_q;
   assign l_rdata   = l_rdata_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_q     <= GNT_L;
         addr_q     <= '0;
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         f_rdata_q  <= '0;
         l_rdata_q  <= '0;
      end else begin
         last_q     <= last_d;
         addr_q     <= mem_addr;
         f_rvalid_q <= f_gnt_s;
         l_rvalid_q <= l_gnt_s;
         if (f_gnt_s) begin
            f_rdata_q <= mem_rdata;
         end
         if (l_gnt_s) begin
            l_rdata_q <= l_we ? '0 : mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter; the bench owns the 32-word memory model.
// Lock expectations follow LOADER_LOCK_EN when it is defined for the build.
module tb_imem_arbiter;

   logic        CLK;
   logic        RST;
   logic        f_req;
   logic [4:0]  f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        l_req;
   logic        l_we;
   logic [4:0]  l_addr;
   logic [31:0] l_wdata;
   logic        l_lock;
   logic        l_gnt;
   logic        l_rvalid;
   logic [31:0] l_rdata;
   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [32];
   logic        tb_init;
   int          total;
   int          bad;

   imem_arbiter #(.DW(32), .AW(5), .MAX_LOCK(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_gnt     (f_gnt),
      .f_rvalid  (f_rvalid),
      .f_rdata   (f_rdata),
      .l_req     (l_req),
      .l_we      (l_we),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .l_lock    (l_lock),
      .l_gnt     (l_gnt),
      .l_rvalid  (l_rvalid),
      .l_rdata   (l_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [31:0] init_word(int a);
      return 32'hC0DE_0000 + 32'(a) * 32'h0000_0101;
   endfunction

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   assign mem_rdata = mem[mem_addr];

   always @(posedge CLK) begin
      if (tb_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic do_reset();
      RST = 1'b1;
      f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; tb_init = 1'b1;
      f_req = 1'b1; l_req = 1'b1; l_we = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      tb_init = 1'b0;
      #1;
      total++;
      if ({f_gnt, l_gnt, mem_we} !== 3'b000) begin
         bad++; $display("FAIL reset_gnt: got %b want 000", {f_gnt, l_gnt, mem_we});
      end
      total++;
      if ({f_rvalid, l_rvalid} !== 2'b00) begin
         bad++; $display("FAIL reset_rvalid: got %b want 00", {f_rvalid, l_rvalid});
      end
      total++;
      if ({f_rdata, l_rdata} !== 64'h0) begin
         bad++; $display("FAIL reset_rdata: got %h %h want 0 0", f_rdata, l_rdata);
      end
      f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_fetch_only();
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (i > 0) begin
            total++;
            if (f_rvalid !== 1'b1 || f_rdata !== init_word(i - 1)) begin
               bad++; $display("FAIL fetch_rdata[%0d]: got v=%b %h want v=1 %h", i - 1, f_rvalid, f_rdata, init_word(i - 1));
            end
         end
         if (i < 4) begin
            f_req = 1'b1; f_addr = 5'(i);
            #1;
            total++;
            if ({f_gnt, l_gnt} !== 2'b10 || mem_addr !== 5'(i)) begin
               bad++; $display("FAIL fetch_gnt[%0d]: got gnt=%b addr=%0d want gnt=10 addr=%0d", i, {f_gnt, l_gnt}, mem_addr, i);
            end
         end else begin
            f_req = 1'b0;
            #1;
            total++;
            if (f_gnt !== 1'b0 || mem_addr !== 5'd3 || mem_we !== 1'b0) begin
               bad++; $display("FAIL idle_hold: got gnt=%b addr=%0d we=%b want 0 3 0", f_gnt, mem_addr, mem_we);
            end
         end
      end
      @(negedge CLK);
      total++;
      if (f_rvalid !== 1'b0) begin
         bad++; $display("FAIL fetch_rvalid_drop: got %b want 0", f_rvalid);
      end
   endtask

   task automatic test_loader_read_top();
      l_req = 1'b1; l_we = 1'b0; l_addr = 5'd31;
      #1;
      total++;
      if ({f_gnt, l_gnt} !== 2'b01 || mem_addr !== 5'd31 || mem_we !== 1'b0) begin
         bad++; $display("FAIL top_read_issue: got gnt=%b addr=%0d we=%b want 01 31 0", {f_gnt, l_gnt}, mem_addr, mem_we);
      end
      @(negedge CLK);
      total++;
      if (l_rvalid !== 1'b1 || l_rdata !== init_word(31) || mem_we !== 1'b0) begin
         bad++; $display("FAIL top_read_data: got v=%b %h we=%b want v=1 %h we=0", l_rvalid, l_rdata, mem_we, init_word(31));
      end
      l_req = 1'b0;
      #1;
      total++;
      if (mem_addr !== 5'd31 || mem_we !== 1'b0) begin
         bad++; $display("FAIL top_read_hold: got addr=%0d we=%b want 31 0", mem_addr, mem_we);
      end
      @(negedge CLK);
   endtask

   task automatic test_write_then_read();
      l_req = 1'b1; l_we = 1'b1; l_addr = 5'd5; l_wdata = 32'hDEAD_BEEF;
      #1;
      total++;
      if (l_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd5 || mem_wdata !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL write_issue: got gnt=%b we=%b addr=%0d wd=%h want 1 1 5 deadbeef", l_gnt, mem_we, mem_addr, mem_wdata);
      end
      @(negedge CLK);
      total++;
      if (l_rvalid !== 1'b1 || l_rdata !== 32'h0) begin
         bad++; $display("FAIL write_ack: got v=%b %h want v=1 0", l_rvalid, l_rdata);
      end
      l_req = 1'b0; l_we = 1'b0;
      f_req = 1'b1; f_addr = 5'd5;
      #1;
      total++;
      if ({f_gnt, l_gnt, mem_we} !== 3'b100) begin
         bad++; $display("FAIL readback_issue: got %b want 100", {f_gnt, l_gnt, mem_we});
      end
      @(negedge CLK);
      total++;
      if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL readback_data: got v=%b %h want v=1 deadbeef", f_rvalid, f_rdata);
      end
      f_req = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_contention();
      logic exp_f;
      do_reset();
      f_addr = 5'd1; l_addr = 5'd2; l_we = 1'b0; l_lock = 1'b0;
      f_req = 1'b1; l_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_f = ((k % 2) == 0);
         #1;
         total++;
         if ({f_gnt, l_gnt} !== (exp_f ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, {f_gnt, l_gnt}, exp_f ? 2'b10 : 2'b01);
         end
         if (k > 0) begin
            total++;
            if ({f_rvalid, l_rvalid} !== (exp_f ? 2'b01 : 2'b10)) begin
               bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, {f_rvalid, l_rvalid}, exp_f ? 2'b01 : 2'b10);
            end
         end
         @(negedge CLK);
      end
      total++;
      if (f_rdata !== init_word(1) || l_rdata !== init_word(2)) begin
         bad++; $display("FAIL rr_rdata: got %h %h want %h %h", f_rdata, l_rdata, init_word(1), init_word(2));
      end
      f_req = 1'b0; l_req = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_lock();
      logic exp_l;
      do_reset();
      l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = 5'd20; l_wdata = 32'h5A5A_0000;
      f_req = 1'b0; f_addr = 5'd3;
      for (int k = 0; k < 10; k++) begin
`ifdef LOADER_LOCK_EN
         exp_l = (k != 8);
`else
         exp_l = ((k % 2) == 0);
`endif
         #1;
         total++;
         if ({f_gnt, l_gnt} !== (exp_l ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL lock_gnt[%0d]: got %b want %b", k, {f_gnt, l_gnt}, exp_l ? 2'b01 : 2'b10);
         end
         @(negedge CLK);
         f_req = 1'b1;
      end
      f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      f_req = 1'b1; f_addr = 5'd2;
      #1;
      total++;
      if (f_gnt !== 1'b1) begin
         bad++; $display("FAIL mid_issue: got %b want 1", f_gnt);
      end
      @(posedge CLK);
      #1;
      total++;
      if (f_rvalid !== 1'b1 || f_rdata !== init_word(2)) begin
         bad++; $display("FAIL mid_pre: got v=%b %h want v=1 %h", f_rvalid, f_rdata, init_word(2));
      end
      RST = 1'b1;
      #1;
      total++;
      if ({f_rvalid, l_rvalid, f_gnt, l_gnt} !== 4'b0000 || f_rdata !== 32'h0) begin
         bad++; $display("FAIL mid_async: got %b %h want 0000 0", {f_rvalid, l_rvalid, f_gnt, l_gnt}, f_rdata);
      end
      l_req = 1'b1; l_we = 1'b1; l_addr = 5'd7;
      #1;
      total++;
      if ({mem_we, l_gnt} !== 2'b00) begin
         bad++; $display("FAIL mid_nowrite: got %b want 00", {mem_we, l_gnt});
      end
      @(negedge CLK);
      f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
      RST = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      total = 0; bad = 0;
      RST = 1'b1; tb_init = 1'b0;
      f_req = 1'b0; f_addr = 5'd0;
      l_req = 1'b0; l_we = 1'b0; l_addr = 5'd0; l_wdata = 32'h0; l_lock = 1'b0;
      test_reset();
      test_fetch_only();
      test_loader_read_top();
      test_write_then_read();
      test_contention();
      test_lock();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
